fetch_unit: RTL and testbench

- Front-end instruction fetch stage; the consuming end of the writeback stage's flush/flush_addr redirect and halt_out signals.
- Owns the fetch PC and issues one instruction-memory request at a time.
- Presents PC/instr/pipeline_valid to decode under a stall handshake.
- Discards in-flight fetches on flush; stops permanently on halt.

---
 rtl/fetch_unit.sv | 198 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Front-end instruction fetch stage. It owns the fetch PC, issues one
// instruction-memory request at a time, and presents PC/instr to decode under
// a stall handshake. A writeback redirect (flush/flush_addr) discards in-flight
// fetches. A sticky halt stops the unit until reset.
//
// Optional feature macro: FETCH_MISALIGN_EXC_EN
//   Defined   : a flush to a non-word-aligned address issues no request. It
//               presents a single instruction-address-misaligned exception
//               (exception=0) and then idles until the next flush.
//   Undefined : flush_addr[1:0] is ignored and exception_valid stays 0.
//
// Ports
//   clk              clock, all state on rising edge
//   reset            asynchronous active-low reset
//   flush/flush_addr redirect request and target PC from writeback
//   halt             sticky halt from writeback
//   stall            decode not ready; hold the presented instruction
//   imem_req/addr    single-cycle request strobe and address
//   imem_resp_valid  response strobe; imem_resp_data carries the word
//   PC/instr         presented instruction and its PC
//   pipeline_valid   PC/instr valid to decode
//   exception_valid  fetch exception flag (qualified by pipeline_valid)
//   exception        exception cause
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  input  logic        halt,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] PC,
  output logic [31:0] instr,
  output logic        pipeline_valid,
  output logic        exception_valid,
  output logic [3:0]  exception
);

  // S_EXC is only entered when the misaligned-flush exception is built in.
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALTED, S_EXC
  } state_t;

  state_t      state_q, state_d;
  logic        kill_q, kill_d;           // drop the next response
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] buf_q, buf_d;             // one-entry response buffer (HOLD)
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        exc_valid_q, exc_valid_d;
  logic        load;
  logic [31:0] load_data;

  // The request is a pure function of state, so it is high for exactly the
  // single REQ cycle.
  assign imem_req        = (state_q == S_REQ);
  assign imem_addr       = (state_q == S_REQ) ? fetch_pc_q : 32'h0;
  assign PC              = pc_q;
  assign instr           = instr_q;
  assign pipeline_valid  = valid_q;
  assign exception_valid = exc_valid_q;
  assign exception       = 4'd0;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; a missed assignment in always_comb infers a latch.
    state_d     = state_q;
    kill_d      = kill_q;
    fetch_pc_d  = fetch_pc_q;
    buf_d       = buf_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    exc_valid_d = exc_valid_q;
    load        = 1'b0;
    load_data   = imem_resp_data;

    if (state_q == S_HALTED) begin
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
      exc_valid_d = 1'b0;
    end else if (halt) begin
      // Halt wins over a simultaneous flush; the outstanding response is
      // simply never consumed.
      state_d     = S_HALTED;
      kill_d      = 1'b0;
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
      exc_valid_d = 1'b0;
    end else if (flush) begin
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
      exc_valid_d = 1'b0;
      fetch_pc_d  = flush_addr & ~32'h3;
      // A request still in flight must have its response discarded. A
      // response arriving in the flush cycle itself is dropped right here.
      case (state_q)
        S_REQ:   kill_d = 1'b1;
        S_WAIT:  kill_d = !imem_resp_valid;
        S_EXC:   if (imem_resp_valid) kill_d = 1'b0;
        default: ;
      endcase
      if (state_q == S_REQ || (state_q == S_WAIT && !imem_resp_valid))
        state_d = S_WAIT;
      else
        state_d = S_REQ;
`ifdef FETCH_MISALIGN_EXC_EN
      if (flush_addr[1:0] != 2'b00) begin
        state_d     = S_EXC;
        fetch_pc_d  = flush_addr;
        pc_d        = flush_addr;
        valid_d     = 1'b1;
        exc_valid_d = 1'b1;
      end
`endif
    end else begin
      // Decode consumed (or never had) the presented slot.
      if (!stall) begin
        valid_d     = 1'b0;
        instr_d     = NOP_INSTR;
        exc_valid_d = 1'b0;
      end
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ:  state_d = S_WAIT;
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (!valid_q || !stall) begin
              load = 1'b1;
            end else begin
              buf_d   = imem_resp_data;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load      = 1'b1;
            load_data = buf_q;
          end
        end
        S_EXC: begin
          // Idle until the next flush; a stale response only retires the kill.
          if (imem_resp_valid) kill_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
      if (load) begin
        pc_d        = fetch_pc_q;
        instr_d     = load_data;
        valid_d     = 1'b1;
        exc_valid_d = 1'b0;
        fetch_pc_d  = fetch_pc_q + 32'd4;
        state_d     = S_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the buffer is a single register, so it is reset with the rest;
      // its contents are never observed unless state is HOLD.
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      buf_q       <= 32'h0;
      pc_q        <= 32'h0;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      exc_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      kill_q      <= kill_d;
      fetch_pc_q  <= fetch_pc_d;
      buf_q       <= buf_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      exc_valid_q <= exc_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with RESET_PC=32'h100. A behavioural memory
// answers each request after a programmable number of cycles with either a
// fixed word or the bitwise inverse of the request address. Inputs and
// observations both happen on the falling clock edge. The memory model acts
// 1 time unit later so that scenario tasks can retune it on the same edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_addr;
  logic        halt;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] PC;
  logic [31:0] instr;
  logic        pipeline_valid;
  logic        exception_valid;
  logic [3:0]  exception;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        exc_valid;
    logic [3:0]  exc;
  } obs_t;

  int unsigned cmps  = 0;
  int unsigned fails = 0;
  obs_t        obs, exp;

  // Memory model controls.
  int          lat        = 1;
  bit          use_fixed  = 1'b1;
  logic [31:0] fixed_data = 32'h0000_000A;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .flush_addr      (flush_addr),
    .halt            (halt),
    .stall           (stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .PC              (PC),
    .instr           (instr),
    .pipeline_valid  (pipeline_valid),
    .exception_valid (exception_valid),
    .exception       (exception)
  );

  always #5 clk = ~clk;

  // Memory: a request seen in cycle n is answered (valid for one cycle)
  // in cycle n+lat.
  initial begin
    int          cd;
    logic [31:0] raddr;
    cd              = 0;
    raddr           = 32'h0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = use_fixed ? fixed_data : ~raddr;
        end
      end
      if (imem_req) begin
        cd    = lat;
        raddr = imem_addr;
      end
    end
  end

  function automatic obs_t sample();
    return '{imem_req, imem_addr, PC, instr, pipeline_valid, exception_valid, exception};
  endfunction

  function automatic obs_t mk(logic r, logic [31:0] a, logic [31:0] p, logic [31:0] i,
                              logic v, logic ev);
    return '{r, a, p, i, v, ev, 4'd0};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Reset values, then first-fetch latency with a fixed 32'hA memory word.
  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; flush_addr = 32'h0; halt = 1'b0; stall = 1'b0;
    lat = 1; use_fixed = 1'b1;
    step(); step();
    exp = mk(0, 0, 0, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL reset_values: got %p expected %p", obs, exp); end
    reset = 1'b1;                                    // cycle 0
    step();                                          // cycle 1
    exp = mk(1, RST_PC, 0, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL first_req: got %p expected %p", obs, exp); end
    step();                                          // cycle 2
    exp = mk(0, 0, 0, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL first_wait: got %p expected %p", obs, exp); end
    step();                                          // cycle 3
    exp = mk(1, 32'h104, 32'h100, 32'hA, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL first_instr: got %p expected %p", obs, exp); end
    step();                                          // cycle 4
    exp = mk(0, 0, 32'h100, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL slot_drained: got %p expected %p", obs, exp); end
    step();                                          // cycle 5
    exp = mk(1, 32'h108, 32'h104, 32'hA, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL second_instr: got %p expected %p", obs, exp); end
  endtask

  // Stall for 4 cycles while a response arrives: it is buffered, the outputs
  // hold, and no new request goes out until decode frees the slot.
  task automatic test_stall();
    stall = 1'b1; use_fixed = 1'b0;                  // cycle 5
    for (int c = 6; c <= 9; c++) begin
      step();
      exp = mk(0, 0, 32'h104, 32'hA, 1, 0); obs = sample(); cmps++;
      if (obs !== exp) begin fails++; $display("FAIL stall_hold_c%0d: got %p expected %p", c, obs, exp); end
    end
    stall = 1'b0;                                    // cycle 9
    step();                                          // cycle 10
    exp = mk(1, 32'h10C, 32'h108, ~32'h108, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL stall_release: got %p expected %p", obs, exp); end
  endtask

  // Flush during WAIT, response 2 cycles later is dropped.
  task automatic test_flush_wait();
    lat = 3;                                         // req 10C in cycle 10
    step();                                          // cycle 11 (WAIT)
    exp = mk(0, 0, 32'h108, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL fw_wait: got %p expected %p", obs, exp); end
    flush = 1'b1; flush_addr = 32'h200;
    for (int c = 12; c <= 13; c++) begin
      step();
      flush = 1'b0;
      exp = mk(0, 0, 32'h108, NOP, 0, 0); obs = sample(); cmps++;
      if (obs !== exp) begin fails++; $display("FAIL fw_drop_c%0d: got %p expected %p", c, obs, exp); end
    end
    step();                                          // cycle 14
    lat = 1;
    exp = mk(1, 32'h200, 32'h108, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL fw_redirect_req: got %p expected %p", obs, exp); end
    step();                                          // cycle 15
    exp = mk(0, 0, 32'h108, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL fw_not_valid: got %p expected %p", obs, exp); end
    step();                                          // cycle 16
    exp = mk(1, 32'h204, 32'h200, ~32'h200, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL fw_target_instr: got %p expected %p", obs, exp); end
  endtask

  // Flush coinciding with the response: dropped, request to target next cycle.
  task automatic test_flush_same_cycle();
    step();                                          // cycle 17, resp for 204
    flush = 1'b1; flush_addr = 32'h300;
    step();                                          // cycle 18
    flush = 1'b0;
    exp = mk(1, 32'h300, 32'h200, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL fs_req: got %p expected %p", obs, exp); end
    step(); step();                                  // cycle 20
    exp = mk(1, 32'h304, 32'h300, ~32'h300, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL fs_instr: got %p expected %p", obs, exp); end
  endtask

  // Flush in REQ kills the request issued that same cycle.
  task automatic test_flush_req();
    flush = 1'b1; flush_addr = 32'h400;              // cycle 20 (REQ 304)
    step();                                          // cycle 21, resp dropped
    flush = 1'b0;
    exp = mk(0, 0, 32'h300, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL fr_wait: got %p expected %p", obs, exp); end
    step();                                          // cycle 22
    exp = mk(1, 32'h400, 32'h300, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL fr_req: got %p expected %p", obs, exp); end
    step(); step();                                  // cycle 24
    exp = mk(1, 32'h404, 32'h400, ~32'h400, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL fr_instr: got %p expected %p", obs, exp); end
  endtask

  // fetch_pc 32'hFFFF_FFFC + 4 wraps to 0.
  task automatic test_wrap();
    flush = 1'b1; flush_addr = 32'hFFFF_FFFC;        // cycle 24 (REQ 404)
    step(); flush = 1'b0; step();                    // cycle 26
    exp = mk(1, 32'hFFFF_FFFC, 32'h400, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL wrap_req: got %p expected %p", obs, exp); end
    step(); step();                                  // cycle 28
    exp = mk(1, 32'h0, 32'hFFFF_FFFC, 32'h3, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL wrap_next_addr: got %p expected %p", obs, exp); end
  endtask

  // Halt with a simultaneous flush: halted until reset, then restart at RESET_PC.
  task automatic test_halt();
    step();                                          // cycle 29, WAIT + resp
    halt = 1'b1; flush = 1'b1; flush_addr = 32'h500;
    for (int c = 0; c < 8; c++) begin
      step();
      flush = 1'b0;
      if (c == 4) begin halt = 1'b0; flush = 1'b1; flush_addr = 32'h600; end
      exp = mk(0, 0, 32'hFFFF_FFFC, NOP, 0, 0); obs = sample(); cmps++;
      if (obs !== exp) begin fails++; $display("FAIL halted_%0d: got %p expected %p", c, obs, exp); end
    end
    flush = 1'b0;
    reset = 1'b0;
    step();
    exp = mk(0, 0, 0, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL halt_reset: got %p expected %p", obs, exp); end
    reset = 1'b1;
    step();                                          // cycle 1
    exp = mk(1, RST_PC, 0, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL restart_req: got %p expected %p", obs, exp); end
    step(); step();                                  // cycle 3
    exp = mk(1, 32'h104, 32'h100, ~32'h100, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL restart_instr: got %p expected %p", obs, exp); end
  endtask

  // Flush to 32'h202 while stalled (stall ignored for the flush cycle).
  task automatic test_misalign();
    stall = 1'b1; flush = 1'b1; flush_addr = 32'h202; // cycle 3 (REQ 104)
`ifdef FETCH_MISALIGN_EXC_EN
    for (int c = 4; c <= 5; c++) begin
      step();
      flush = 1'b0;
      exp = mk(0, 0, 32'h202, NOP, 1, 1); obs = sample(); cmps++;
      if (obs !== exp) begin fails++; $display("FAIL mis_exc_c%0d: got %p expected %p", c, obs, exp); end
    end
    stall = 1'b0;                                    // cycle 5
    for (int c = 6; c <= 7; c++) begin
      step();
      exp = mk(0, 0, 32'h202, NOP, 0, 0); obs = sample(); cmps++;
      if (obs !== exp) begin fails++; $display("FAIL mis_idle_c%0d: got %p expected %p", c, obs, exp); end
    end
    flush = 1'b1; flush_addr = 32'h300;              // cycle 7
    step();                                          // cycle 8
    flush = 1'b0;
    exp = mk(1, 32'h300, 32'h202, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL mis_recover_req: got %p expected %p", obs, exp); end
    step(); step();                                  // cycle 10
    exp = mk(1, 32'h304, 32'h300, ~32'h300, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL mis_recover_instr: got %p expected %p", obs, exp); end
`else
    step();                                          // cycle 4
    flush = 1'b0;
    exp = mk(0, 0, 32'h100, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL align_flush: got %p expected %p", obs, exp); end
    step();                                          // cycle 5
    stall = 1'b0;
    exp = mk(1, 32'h200, 32'h100, NOP, 0, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL align_req: got %p expected %p", obs, exp); end
    step(); step();                                  // cycle 7
    exp = mk(1, 32'h204, 32'h200, ~32'h200, 1, 0); obs = sample(); cmps++;
    if (obs !== exp) begin fails++; $display("FAIL align_instr: got %p expected %p", obs, exp); end
`endif
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush_wait();
    test_flush_same_cycle();
    test_flush_req();
    test_wrap();
    test_halt();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
